// File: rtl/gcm_lane_scheduler.sv
// Round-robin dispatcher of GCM jobs onto parallel AES-GCM lanes.
// Tracks per-lane busy state and quarantines lanes whose cores stay blocked.
module gcm_lane_scheduler #(
    parameter int N_REQ   = 2,
    parameter int N_LANE  = 4,
    parameter int SRC_W   = 3,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_LANE-1:0]       lane_start,
    output logic [N_LANE*SRC_W-1:0] lane_src,
    input  logic [N_LANE-1:0]       lane_done,
    input  logic [N_LANE-1:0]       lane_block,
    output logic [N_LANE-1:0]       lane_busy,
    output logic [N_LANE-1:0]       done_valid,
    output logic [N_LANE-1:0]       deadlock_lane,
    output logic                    deadlock
);

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    logic [N_LANE-1:0]       busy_q, busy_d;
    logic [N_LANE-1:0]       dead_q, dead_d;
    logic [N_LANE-1:0]       start_q, start_d;
    logic [N_LANE-1:0]       done_q, done_d;
    logic [N_LANE*SRC_W-1:0] src_q, src_d;
    logic [SRC_W-1:0]        rr_q, rr_d;
    logic [CNT_W-1:0]        cnt_q [N_LANE];
    logic [CNT_W-1:0]        cnt_d [N_LANE];

    logic [N_LANE-1:0] free;
    logic [N_LANE-1:0] lane_oh;
    logic [N_REQ-1:0]  gnt_oh;
    logic [SRC_W-1:0]  gnt_idx;
    logic              found;
    logic              fire;

    // Two passes give the first valid requester at or after rr, wrapping.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int r = 0; r < N_REQ; r++) begin
            if (!found && req_valid[r] && (r >= int'(rr_q))) begin
                found     = 1'b1;
                gnt_idx   = SRC_W'(r);
                gnt_oh[r] = 1'b1;
            end
        end
        for (int r = 0; r < N_REQ; r++) begin
            if (!found && req_valid[r]) begin
                found     = 1'b1;
                gnt_idx   = SRC_W'(r);
                gnt_oh[r] = 1'b1;
            end
        end
    end

    always_comb begin
        free    = ~busy_q & ~dead_q;
        lane_oh = '0;
        for (int l = N_LANE - 1; l >= 0; l--) begin
            if (free[l]) begin
                lane_oh    = '0;
                lane_oh[l] = 1'b1;
            end
        end
    end

    assign fire      = found & (|free);
    assign req_ready = fire ? gnt_oh : '0;

    always_comb begin
        start_d = fire ? lane_oh : '0;
        done_d  = lane_done & busy_q;
        busy_d  = (busy_q & ~done_d) | start_d;
        src_d   = src_q;
        rr_d    = rr_q;
        dead_d  = dead_q;
        if (fire) begin
            rr_d = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        for (int l = 0; l < N_LANE; l++) begin
            if (start_d[l]) begin
                src_d[l*SRC_W +: SRC_W] = gnt_idx;
            end
            if (busy_q[l] && lane_block[l]) begin
                cnt_d[l] = (cnt_q[l] == TO) ? TO : cnt_q[l] + 1'b1;
            end else begin
                cnt_d[l] = '0;
            end
            if (cnt_q[l] == TO) begin
                dead_d[l] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q  <= '0;
            dead_q  <= '0;
            start_q <= '0;
            done_q  <= '0;
            src_q   <= '0;
            rr_q    <= '0;
            for (int l = 0; l < N_LANE; l++) begin
                cnt_q[l] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            dead_q  <= dead_d;
            start_q <= start_d;
            done_q  <= done_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
            for (int l = 0; l < N_LANE; l++) begin
                cnt_q[l] <= cnt_d[l];
            end
        end
    end

    assign lane_start    = start_q;
    assign lane_src      = src_q;
    assign lane_busy     = busy_q;
    assign done_valid    = done_q;
    assign deadlock_lane = dead_q;
    assign deadlock      = |dead_q;

endmodule
